fpu_byte_link: RTL and testbench

Parametrised byte-serial bridge between the 8-bit pad interface and an FPU datapath core. It assembles a frame of `NUM_OPS` operands from a handshaked byte stream, and issues the frame to the core with a valid/ready handshake. It captures the core result and streams it back out byte by byte. It replaces free-running shift-in/shift-out capture with explicit flow control, a flush, and a frame counter.

---
 rtl/fpu_byte_link_if.sv | 71 +++++++
 rtl/fpu_byte_link.sv | 178 +++++++++++++++++
 tb/tb_fpu_byte_link.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_byte_link_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_byte_link_if
// Description : Bundle of the byte-stream, operand, result and status signals
//               of the byte-serial FPU bridge.
//               master : the bridge itself (fpu_byte_link)
//               slave  : pads, FPU core and status consumer around it
//               Signals:
//                 flush            abort the frame in progress
//                 in_byte/valid/ready   inbound byte stream
//                 ops/ops_valid/ready   operand frame towards the core
//                 res/res_valid/ready   result from the core
//                 out_byte/valid/ready  outbound byte stream
//                 frames_done      completed-frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_byte_link_if #(
    parameter int NUM_OPS   = 4,
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 32
);
    logic                          flush;
    logic [7:0]                    in_byte;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_OPS*OP_WIDTH-1:0]   ops;
    logic                          ops_valid;
    logic                          ops_ready;
    logic [RES_WIDTH-1:0]          res;
    logic                          res_valid;
    logic                          res_ready;
    logic [7:0]                    out_byte;
    logic                          out_valid;
    logic                          out_ready;
    logic [7:0]                    frames_done;

    modport master (
        input  flush,
        input  in_byte,
        input  in_valid,
        output in_ready,
        output ops,
        output ops_valid,
        input  ops_ready,
        input  res,
        input  res_valid,
        output res_ready,
        output out_byte,
        output out_valid,
        input  out_ready,
        output frames_done
    );

    modport slave (
        output flush,
        output in_byte,
        output in_valid,
        input  in_ready,
        input  ops,
        input  ops_valid,
        output ops_ready,
        output res,
        output res_valid,
        input  res_ready,
        input  out_byte,
        input  out_valid,
        output out_ready,
        input  frames_done
    );
endinterface
`default_nettype wire

// File: rtl/fpu_byte_link.sv
`default_nettype none
// ============================================================================
// Module      : fpu_byte_link
// Description : Byte-serial bridge between an 8-bit pad stream and an FPU
//               datapath core. Assembles NUM_OPS operands from inbound bytes,
//               offers them to the core with valid/ready, captures the core
//               result and streams it back out MSB byte first.
//               Ports:
//                 clk  - single clock, rising edge
//                 rst  - asynchronous active-high reset
//                 bus  - fpu_byte_link_if.master (streams, operands, result,
//                        flush and frame counter)
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_byte_link #(
    parameter int NUM_OPS   = 4,
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fpu_byte_link_if.master  bus
);

    localparam int c_ops_w     = NUM_OPS * OP_WIDTH;
    localparam int c_in_bytes  = c_ops_w / 8;
    localparam int c_out_bytes = RES_WIDTH / 8;
    localparam int c_max_bytes = (c_in_bytes > c_out_bytes) ? c_in_bytes : c_out_bytes;
    localparam int c_cnt_w     = $clog2(c_max_bytes + 1);

    localparam logic [c_cnt_w-1:0] c_in_last  = c_cnt_w'(c_in_bytes - 1);
    localparam logic [c_cnt_w-1:0] c_out_last = c_cnt_w'(c_out_bytes - 1);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_ops_w-1:0]     r_ops;
    logic [RES_WIDTH-1:0]   r_res;
    logic [7:0]             r_frames;

    logic                   w_in_fire;
    logic                   w_res_fire;
    logic                   w_out_fire;
    logic                   w_cnt_clr;
    logic                   w_frame_done;
    logic [c_ops_w-1:0]     w_ops_shift;
    logic [RES_WIDTH-1:0]   w_res_shift;

    // Shift paths; a single-byte register degenerates to a plain load / clear.
    if (c_ops_w > 8) begin : g_ops_wide
        assign w_ops_shift = {r_ops[c_ops_w-9:0], bus.in_byte};
    end else begin : g_ops_byte
        assign w_ops_shift = bus.in_byte;
    end

    if (RES_WIDTH > 8) begin : g_res_wide
        assign w_res_shift = {r_res[RES_WIDTH-9:0], 8'h00};
    end else begin : g_res_byte
        assign w_res_shift = '0;
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake qualification. Flush overrides every
    // handshake, so no byte or result is taken in a flush cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_in_fire    = 1'b0;
        w_res_fire   = 1'b0;
        w_out_fire   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_frame_done = 1'b0;

        if (bus.flush) begin
            w_next_state = S_LOAD;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        w_in_fire = 1'b1;
                        if (r_cnt == c_in_last) begin
                            w_next_state = S_ISSUE;
                            w_cnt_clr    = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.ops_ready) begin
                        w_next_state = S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (bus.res_valid) begin
                        w_res_fire   = 1'b1;
                        w_next_state = S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.out_ready) begin
                        w_out_fire = 1'b1;
                        if (r_cnt == c_out_last) begin
                            w_next_state = S_LOAD;
                            w_cnt_clr    = 1'b1;
                            w_frame_done = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = S_LOAD;
                    w_cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers. The operand register is only ever overwritten by
    // new bytes, so the last complete frame stays visible on ops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ops    <= '0;
            r_res    <= '0;
            r_frames <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_in_fire || w_out_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_in_fire) begin
                r_ops <= w_ops_shift;
            end

            if (w_res_fire) begin
                r_res <= bus.res;
            end else if (w_out_fire) begin
                r_res <= w_res_shift;
            end

            if (w_frame_done) begin
                r_frames <= r_frames + 8'd1;
            end
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output paths.
    assign bus.in_ready    = (r_state == S_LOAD);
    assign bus.ops_valid   = (r_state == S_ISSUE);
    assign bus.res_ready   = (r_state == S_WAIT_RES);
    assign bus.out_valid   = (r_state == S_SEND);
    assign bus.ops         = r_ops;
    assign bus.out_byte    = r_res[RES_WIDTH-1 -: 8];
    assign bus.frames_done = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_fpu_byte_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_byte_link
// Description : Self-checking bench for fpu_byte_link. A default-parameter
//               instance runs a table of per-cycle vectors (load, issue
//               backpressure, result serialisation) followed by flush and
//               asynchronous-reset sequences; a second instance with
//               NUM_OPS=2, OP_WIDTH=16, RES_WIDTH=24 covers a reduced frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_byte_link;

    logic clk;
    logic rst;

    fpu_byte_link_if #(.NUM_OPS(4), .OP_WIDTH(32), .RES_WIDTH(32)) bus_a ();
    fpu_byte_link_if #(.NUM_OPS(2), .OP_WIDTH(16), .RES_WIDTH(24)) bus_b ();

    fpu_byte_link #(.NUM_OPS(4), .OP_WIDTH(32), .RES_WIDTH(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fpu_byte_link #(.NUM_OPS(2), .OP_WIDTH(16), .RES_WIDTH(24)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        flush;
        logic        in_v;
        logic [7:0]  in_b;
        logic        ops_rdy;
        logic        res_v;
        logic [31:0] res;
        logic        out_rdy;
        logic [3:0]  hs;       // {in_ready, ops_valid, res_ready, out_valid}
        logic [7:0]  ob;
        logic [7:0]  fd;
        logic        chk_ops;
    } vec_t;

    vec_t vt[$];

    localparam logic [127:0] c_ops_a = 128'h40800000_40000000_3F800000_40400000;
    localparam logic [127:0] c_ops_f = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] ib, logic ordy,
                                logic rv, logic [31:0] r, logic ordy2,
                                logic [3:0] hs, logic [7:0] ob, logic [7:0] fd,
                                logic co);
        vec_t v;
        v.flush = fl; v.in_v = iv; v.in_b = ib; v.ops_rdy = ordy;
        v.res_v = rv; v.res = r; v.out_rdy = ordy2;
        v.hs = hs; v.ob = ob; v.fd = fd; v.chk_ops = co;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] hs_a();
        return {bus_a.in_ready, bus_a.ops_valid, bus_a.res_ready, bus_a.out_valid};
    endfunction

    function automatic logic [3:0] hs_b();
        return {bus_b.in_ready, bus_b.ops_valid, bus_b.res_ready, bus_b.out_valid};
    endfunction

    task automatic idle_a();
        bus_a.flush = 0; bus_a.in_valid = 0; bus_a.in_byte = 8'h00;
        bus_a.ops_ready = 0; bus_a.res_valid = 0; bus_a.res = '0; bus_a.out_ready = 0;
    endtask

    initial begin
        logic [7:0] frame_a [16];
        frame_a = '{8'h40, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
                    8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00};

        // Load, then 5 cycles of issue backpressure with bytes offered
        for (int i = 0; i < 16; i++)
            vt.push_back(mk(0, 1, frame_a[i], 0, 0, 32'h0, 0,
                            (i == 15) ? 4'b0100 : 4'b1000, 8'h00, 8'd0, i == 15));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 1, 8'hAA, 0, 0, 32'h0, 0, 4'b0100, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 1, 8'hAA, 1, 0, 32'h0,        0, 4'b0010, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        1, 4'b0010, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 32'h41200000, 0, 4'b0001, 8'h41, 8'd0, 1));
        // Result serialisation with out_ready toggling; a late res_valid is ignored
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 32'hDEADBEEF, 1, 4'b0001, 8'h20, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        0, 4'b0001, 8'h20, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        1, 4'b0001, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        0, 4'b0001, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        1, 4'b0001, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        0, 4'b0001, 8'h00, 8'd0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        1, 4'b1000, 8'h00, 8'd1, 1));

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle_a();
        bus_b.flush = 0; bus_b.in_valid = 0; bus_b.in_byte = 8'h00;
        bus_b.ops_ready = 0; bus_b.res_valid = 0; bus_b.res = '0; bus_b.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hs", 128'(hs_a()), 128'(4'b1000));
        chk("reset_ops", bus_a.ops, 128'h0);
        chk("reset_out_byte", 128'(bus_a.out_byte), 128'h0);
        chk("reset_frames", 128'(bus_a.frames_done), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // ---------------- table-driven frame ----------------
        foreach (vt[i]) begin
            bus_a.flush     = vt[i].flush;
            bus_a.in_valid  = vt[i].in_v;
            bus_a.in_byte   = vt[i].in_b;
            bus_a.ops_ready = vt[i].ops_rdy;
            bus_a.res_valid = vt[i].res_v;
            bus_a.res       = vt[i].res;
            bus_a.out_ready = vt[i].out_rdy;
            step();
            chk($sformatf("vec%0d_hs", i), 128'(hs_a()), 128'(vt[i].hs));
            chk($sformatf("vec%0d_out_byte", i), 128'(bus_a.out_byte), 128'(vt[i].ob));
            chk($sformatf("vec%0d_frames", i), 128'(bus_a.frames_done), 128'(vt[i].fd));
            if (vt[i].chk_ops)
                chk($sformatf("vec%0d_ops", i), bus_a.ops, c_ops_a);
        end
        chk("ops_op3", 128'(bus_a.ops[127:96]), 128'h40800000);
        chk("ops_op0", 128'(bus_a.ops[31:0]), 128'h40400000);
        idle_a();

        // ---------------- flush mid-load ----------------
        for (int i = 0; i < 7; i++) begin
            bus_a.in_valid = 1; bus_a.in_byte = 8'h11 + 8'(i);
            step();
        end
        bus_a.flush = 1; bus_a.in_byte = 8'hEE;
        step();
        chk("flush_in_ready", 128'(hs_a()), 128'(4'b1000));
        bus_a.flush = 0;
        for (int i = 0; i < 16; i++) begin
            bus_a.in_byte = 8'(i * 17);
            step();
            if (i < 15)
                chk($sformatf("flush_load%0d_hs", i), 128'(hs_a()), 128'(4'b1000));
        end
        chk("flush_issue_hs", 128'(hs_a()), 128'(4'b0100));
        chk("flush_ops", bus_a.ops, c_ops_f);
        chk("flush_frames", 128'(bus_a.frames_done), 128'd1);

        // ---------------- async reset in SEND ----------------
        bus_a.in_valid = 0; bus_a.ops_ready = 1;
        step();
        bus_a.ops_ready = 0; bus_a.res_valid = 1; bus_a.res = 32'hC0A0B0D0;
        step();
        chk("send_first_byte", 128'(bus_a.out_byte), 128'hC0);
        bus_a.res_valid = 0; bus_a.out_ready = 1;
        step();
        step();
        bus_a.out_ready = 0;
        chk("send_third_byte", 128'(bus_a.out_byte), 128'hB0);
        chk("send_hs", 128'(hs_a()), 128'(4'b0001));
        #3;
        rst = 1'b1;
        #1;
        chk("arst_hs", 128'(hs_a()), 128'(4'b1000));
        chk("arst_out_byte", 128'(bus_a.out_byte), 128'h0);
        chk("arst_frames", 128'(bus_a.frames_done), 128'h0);
        chk("arst_ops", bus_a.ops, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_release_hs", 128'(hs_a()), 128'(4'b1000));

        // ---------------- parameter sweep (2 x 16 bit, 24-bit result) ----------------
        begin
            logic [7:0] fb [4];
            logic [7:0] ob [3];
            fb = '{8'h12, 8'h34, 8'h56, 8'h78};
            ob = '{8'hAB, 8'hCD, 8'hEF};
            for (int i = 0; i < 4; i++) begin
                bus_b.in_valid = 1; bus_b.in_byte = fb[i];
                step();
                chk($sformatf("b_load%0d_hs", i), 128'(hs_b()),
                    128'((i == 3) ? 4'b0100 : 4'b1000));
            end
            bus_b.in_valid = 0;
            chk("b_ops", 128'(bus_b.ops), 128'h12345678);
            chk("b_op1", 128'(bus_b.ops[31:16]), 128'h1234);
            bus_b.ops_ready = 1;
            step();
            bus_b.ops_ready = 0;
            chk("b_wait_hs", 128'(hs_b()), 128'(4'b0010));
            bus_b.res_valid = 1; bus_b.res = 24'hABCDEF;
            step();
            bus_b.res_valid = 0; bus_b.out_ready = 1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b_out%0d", i), 128'(bus_b.out_byte), 128'(ob[i]));
                chk($sformatf("b_out%0d_valid", i), 128'(bus_b.out_valid), 128'd1);
                step();
            end
            bus_b.out_ready = 0;
            chk("b_done_hs", 128'(hs_b()), 128'(4'b1000));
            chk("b_frames", 128'(bus_b.frames_done), 128'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
